// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the core datapath and a gnt/rvalid data memory.
// Optional bus timeout abort is built only when LSU_TIMEOUT_EN is defined.
module load_store_unit
`ifdef LSU_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        err_q, err_d;

    logic        req_illegal;
    logic        req_misalign;
    logic        req_fault;
    logic [3:0]  req_be;
    logic [31:0] req_wdata_fmt;
    logic        timeout_hit;

    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Legality, alignment and store-lane formatting of the incoming request.
    always_comb begin
        if (req_we) begin
            req_illegal = (req_funct3 > 3'b010);
        end else begin
            req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        case (req_funct3[1:0])
            2'b00: begin
                req_misalign  = 1'b0;
                req_be        = 4'b0001 << req_addr[1:0];
                req_wdata_fmt = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_misalign  = req_addr[0];
                req_be        = 4'b0011 << {req_addr[1], 1'b0};
                req_wdata_fmt = {2{req_wdata[15:0]}};
            end
            default: begin
                req_misalign  = |req_addr[1:0];
                req_be        = 4'b1111;
                req_wdata_fmt = req_wdata;
            end
        endcase
        req_fault = req_illegal | req_misalign;
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    // Restarts on every entry into REQ or WAIT, including REQ -> WAIT.
    always_comb begin
        cnt_d = '0;
        if ((state_d == StReq || state_d == StWait) && state_d == state_q) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        err_d        = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    lane_d   = req_addr[1:0];
                    if (req_fault) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = StReq;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_we ? req_wdata_fmt : 32'h0;
                    end
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d = StDone;
                    end else if (mem_rvalid) begin
                        state_d      = StDone;
                        resp_rdata_d = load_extract(funct3_q, lane_q, mem_rdata);
                    end else begin
                        state_d = StWait;
                    end
                end else if (timeout_hit) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end
            end
            StWait: begin
                if (mem_rvalid) begin
                    state_d      = StDone;
                    resp_rdata_d = load_extract(funct3_q, lane_q, mem_rdata);
                end else if (timeout_hit) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end
            end
            StDone: begin
                state_d      = StIdle;
                resp_rdata_d = 32'h0;
                err_d        = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        // Bus request is dropped as soon as REQ is left for any reason.
        if (state_q == StReq && state_d != StReq) begin
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = 32'h0;
            mem_be_d    = 4'h0;
            mem_wdata_d = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            lane_q       <= 2'b00;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_be_q     <= 4'h0;
            mem_wdata_q  <= 32'h0;
            resp_rdata_q <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            err_q        <= err_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StDone);
    assign stall      = req_valid & (state_q != StDone);
    assign resp_rdata = resp_rdata_q;
    assign err        = err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized ops vs a byte-level model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, stall, resp_valid, err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef LSU_TIMEOUT_EN
    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
    load_store_unit dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct packed {
        logic        ready;
        logic        seen;
        logic        mwe;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        int          lat;
        int          req_cycles;
        logic [31:0] rdata;
        logic        err;
        logic        stall_bad;
        logic        hold_bad;
        logic        hung;
    } obs_t;

    // Reference model: byte-level view of the RV32I access rules.
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit exp_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] b = 4'h0;
        int off = int'(a % 4);
        for (int i = 0; i < 4; i++) if (i >= off && i < off + size_of(f3)) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size_of(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        longint v = 0;
        int s = size_of(f3);
        int off = int'(a % 4);
        for (int i = 0; i < s; i++) v += longint'(rd[8*(off+i) +: 8]) << (8*i);
        if (!f3[2] && s < 4 && v >= (longint'(1) << (8*s-1))) v -= longint'(1) << (8*s);
        return v[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op from an IDLE cycle, plays the memory side, returns what was observed.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int gnt_wait, input int rv_wait,
                          input logic [31:0] rdata, output obs_t o);
        int   c = 0;
        int   gnt_c = 0;
        logic granted = 1'b0;
        logic done = 1'b0;
        o = '0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        #1;
        o.ready = req_ready;
        if (stall !== 1'b1) o.stall_bad = 1'b1;
        while (!done && c < 64) begin
            tick();
            c++;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (mem_req === 1'b1 && !granted) begin
                if (!o.seen) begin
                    o.mwe = mem_we; o.maddr = mem_addr; o.be = mem_be; o.mwdata = mem_wdata;
                end else if (o.mwe !== mem_we || o.maddr !== mem_addr || o.be !== mem_be ||
                             o.mwdata !== mem_wdata) begin
                    o.hold_bad = 1'b1;
                end
                o.seen = 1'b1;
                if (o.req_cycles >= gnt_wait) begin
                    mem_gnt = 1'b1; granted = 1'b1; gnt_c = c;
                end
                o.req_cycles++;
            end
            if (granted && !we && (c - gnt_c) == rv_wait) begin
                mem_rvalid = 1'b1; mem_rdata = rdata;
            end
            #1;
            if (resp_valid === 1'b1) begin
                done = 1'b1; o.lat = c; o.rdata = resp_rdata; o.err = err;
                if (stall !== 1'b0) o.stall_bad = 1'b1;
            end else if (stall !== 1'b1) begin
                o.stall_bad = 1'b1;
            end
        end
        o.hung = !done;
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [107:0] got;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0;
        req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        got = {req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, resp_valid, resp_rdata,
               err, stall};
        n_checks++;
        if (got !== {1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected ready=1 and all others 0", got);
        end
        req_valid = 1'b1; #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL reset_stall_follow: got %b expected 1", stall);
        end
        req_valid = 1'b0; #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall_low: got %b expected 0", stall);
        end
        tick();
    endtask

    task automatic test_stores();
        obs_t o;
        run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, o);
        n_checks++;
        if ({o.maddr, o.be, o.mwdata, o.mwe} !== {32'h100, 4'b1111, 32'hDEADBEEF, 1'b1}) begin
            n_fail++;
            $display("FAIL sw_bus: got addr %h be %b wdata %h we %b expected 100 1111 deadbeef 1",
                     o.maddr, o.be, o.mwdata, o.mwe);
        end
        n_checks++;
        if (o.lat !== 2 || o.err !== 1'b0 || o.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL sw_resp: got lat %0d err %b rdata %h expected 2 0 0",
                     o.lat, o.err, o.rdata);
        end
        run_op(1'b1, 3'b000, 32'h103, 32'h000000A5, 1, 0, 32'h0, o);
        n_checks++;
        if ({o.maddr, o.be, o.mwdata} !== {32'h100, 4'b1000, 32'hA5A5A5A5}) begin
            n_fail++;
            $display("FAIL sb_bus: got addr %h be %b wdata %h expected 100 1000 a5a5a5a5",
                     o.maddr, o.be, o.mwdata);
        end
        run_op(1'b1, 3'b001, 32'h102, 32'h00001234, 2, 0, 32'h0, o);
        n_checks++;
        if ({o.maddr, o.be, o.mwdata} !== {32'h100, 4'b1100, 32'h12341234}) begin
            n_fail++;
            $display("FAIL sh_bus: got addr %h be %b wdata %h expected 100 1100 12341234",
                     o.maddr, o.be, o.mwdata);
        end
        n_checks++;
        if (o.lat !== 4 || o.hold_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_wait: got lat %0d hold_bad %b expected 4 0", o.lat, o.hold_bad);
        end
    endtask

    task automatic test_loads();
        obs_t o;
        run_op(1'b0, 3'b000, 32'h101, 32'h0, 0, 3, 32'h00008000, o);
        n_checks++;
        if (o.rdata !== 32'hFFFFFF80 || o.lat !== 5 || o.err !== 1'b0 || o.mwe !== 1'b0) begin
            n_fail++;
            $display("FAIL lb: got rdata %h lat %0d err %b we %b expected ffffff80 5 0 0",
                     o.rdata, o.lat, o.err, o.mwe);
        end
        run_op(1'b0, 3'b100, 32'h101, 32'h0, 0, 3, 32'h00008000, o);
        n_checks++;
        if (o.rdata !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu: got %h expected 00000080", o.rdata);
        end
        run_op(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'hBEEF0000, o);
        n_checks++;
        if (o.rdata !== 32'h0000BEEF || o.maddr !== 32'h100 || o.lat !== 2) begin
            n_fail++;
            $display("FAIL lhu: got rdata %h addr %h lat %0d expected 0000beef 100 2",
                     o.rdata, o.maddr, o.lat);
        end
    endtask

    task automatic test_faults();
        obs_t o;
        logic [2:0] f3s [3] = '{3'b010, 3'b011, 3'b100};
        logic       wes [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_op(wes[i], f3s[i], 32'h102, 32'h55, 0, 0, 32'hFFFFFFFF, o);
            n_checks++;
            if (o.lat !== 1 || o.err !== 1'b1 || o.seen !== 1'b0 || o.rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL fault_%0d: got lat %0d err %b mem_req_seen %b rdata %h %s",
                         i, o.lat, o.err, o.seen, o.rdata, "expected 1 1 0 0");
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        int   t0;
        t0 = cyc;
        run_op(1'b1, 3'b010, 32'h40, 32'h11223344, 0, 0, 32'h0, o1);
        run_op(1'b0, 3'b010, 32'h44, 32'h0, 0, 0, 32'hCAFEF00D, o2);
        n_checks++;
        if (o2.ready !== 1'b1 || o2.rdata !== 32'hCAFEF00D || (cyc - t0) !== 6) begin
            n_fail++;
            $display("FAIL back_to_back: got ready %b rdata %h cycles %0d expected 1 cafef00d 6",
                     o2.ready, o2.rdata, cyc - t0);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, wd, rd, exp_rd;
        int          gw, rw, exp_lat;
        bit          f;
        for (int k = 0; k < 40; k++) begin
            we = 1'($urandom); f3 = 3'($urandom_range(0, 7)); a = $urandom; wd = $urandom;
            rd = $urandom; gw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
            f = exp_fault(we, f3, a);
            exp_lat = f ? 1 : (2 + gw + (we ? 0 : rw));
            exp_rd  = (f || we) ? 32'h0 : exp_load(f3, a, rd);
            run_op(we, f3, a, wd, gw, rw, rd, o);
            n_checks++;
            if (o.lat !== exp_lat || o.err !== f || o.rdata !== exp_rd || o.seen !== !f ||
                o.hung || o.stall_bad || o.hold_bad || o.ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_resp %0d: we %b f3 %0d addr %h got lat %0d err %b rdata %h %s%0d %b %h",
                         k, we, f3, a, o.lat, o.err, o.rdata, "expected ", exp_lat, f, exp_rd);
            end
            if (!f) begin
                n_checks++;
                if (o.maddr !== {a[31:2], 2'b00} || o.mwe !== we ||
                    (we && (o.be !== exp_be(f3, a) || o.mwdata !== exp_wdata(f3, wd)))) begin
                    n_fail++;
                    $display("FAIL rand_bus %0d: got addr %h we %b be %b wdata %h expected %h %b %b %h",
                             k, o.maddr, o.mwe, o.be, o.mwdata, {a[31:2], 2'b00}, we,
                             exp_be(f3, a), exp_wdata(f3, wd));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen_resp = 0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
        tick();
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL midrst_req: got mem_req %b expected 1", mem_req);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; rst = 1'b1; req_valid = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_idle: got mem_req %b ready %b expected 0 1", mem_req, req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
            tick();
            if (resp_valid !== 1'b0) seen_resp++;
        end
        mem_rvalid = 1'b0;
        n_checks++;
        if (seen_resp !== 0) begin
            n_fail++; $display("FAIL midrst_late_rvalid: got %0d resp pulses expected 0", seen_resp);
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        run_op(1'b0, 3'b010, 32'h300, 32'h0, 100, 0, 32'h0, o);
        n_checks++;
        if (o.req_cycles !== 4 || o.lat !== 5 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout_req: got req_cycles %0d lat %0d err %b rdata %h expected 4 5 1 0",
                     o.req_cycles, o.lat, o.err, o.rdata);
        end
        run_op(1'b0, 3'b010, 32'h300, 32'h0, 0, 100, 32'h0, o);
        n_checks++;
        if (o.lat !== 6 || o.err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_wait: got lat %0d err %b expected 6 1", o.lat, o.err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_faults();
        test_back_to_back();
        test_random();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
